sm2201_isa_cycle_decoder: RTL and testbench

- ISA-side front end of the SM2201 interface board; sits between the raw ISA slot signals and the CAMAC dataway sequencer.
- Latches the address on ALE and decodes the board's 64-byte I/O window (0x100-0x13F).
- Assembles 8-bit ISA bytes into 16-bit CAMAC words and issues one word request per access pair.
- Holds ISA CHRDY low until the CAMAC side acknowledges, or until a timeout expires.

---
 rtl/sm2201_pkg.sv | 19 +
 rtl/sm2201_isa_strobe_edge.sv | 40 ++++
 rtl/sm2201_isa_cycle_decoder.sv | 147 ++++++++++++++
 tb/tb_sm2201_isa_cycle_decoder.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm2201_pkg.sv
// Shared definitions for the SM2201 ISA front end: FSM states, window geometry, idle read value.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sm2201_pkg;

    localparam int          SM2201_ADDR_W    = 10;
    localparam logic [9:0]  SM2201_BASE_ADDR = 10'h100;
    // The window is 2**SM2201_WIN_BITS bytes; only the address bits above it are decoded.
    localparam int          SM2201_WIN_BITS  = 6;
    // Read cache value after reset or an abandoned read: the ISA bus sees an undriven-looking 0xFF.
    localparam logic [15:0] RD_IDLE          = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } sm2201_state_t;

endpackage

// File: rtl/sm2201_isa_strobe_edge.sv
// Samples the ISA I/O strobes, flags their falling edges and latches the address while ALE is high.
// Latency: a fall is flagged in the cycle the strobe is first seen low; addr_q follows isa_addr on ALE edges.
// Backpressure: none; a pure sampler that tracks the bus every cycle.
module sm2201_isa_strobe_edge
    import sm2201_pkg::*;
(
    input  logic                     isa_clk,
    input  logic                     isa_reset,
    input  logic                     isa_ale,
    input  logic                     isa_ior,
    input  logic                     isa_iow,
    input  logic [SM2201_ADDR_W-1:0] isa_addr,
    output logic [SM2201_ADDR_W-1:0] addr_q,
    output logic                     ior_fall,
    output logic                     iow_fall
);

    logic ior_p;
    logic iow_p;

    // Previous-edge strobe samples (idle high) and the ALE-qualified address latch
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            ior_p  <= 1'b1;
            iow_p  <= 1'b1;
            addr_q <= '0;
        end else begin
            ior_p <= isa_ior;
            iow_p <= isa_iow;
            if (isa_ale) begin
                addr_q <= isa_addr;
            end
        end
    end

    // A fall is "was high at the last edge, low now"
    assign ior_fall = ior_p & ~isa_ior;
    assign iow_fall = iow_p & ~isa_iow;

endmodule

// File: rtl/sm2201_isa_cycle_decoder.sv
// ISA front end of the SM2201: decodes the 64-byte I/O window, pairs bytes into CAMAC words, issues word requests.
// Latency: request and CHRDY low one edge after the strobe fall; CHRDY released one edge after ack or timeout.
// Backpressure: ISA wait states via CHRDY until the CAMAC side acks or WAIT_TIMEOUT cycles elapse.
module sm2201_isa_cycle_decoder
    import sm2201_pkg::*;
#(
    parameter logic [9:0] BASE_ADDR    = SM2201_BASE_ADDR,
    parameter int         WAIT_TIMEOUT = 255
) (
    input  logic        isa_clk,
    input  logic        isa_reset,
    input  logic        isa_ale,
    input  logic        isa_aen,
    input  logic        isa_ior,
    input  logic        isa_iow,
    input  logic [9:0]  isa_addr,
    input  logic [7:0]  isa_data_in,
    output logic [7:0]  isa_data_out,
    output logic        isa_data_oe,
    output logic        isa_chrdy,
    output logic        cam_req,
    output logic        cam_write,
    output logic [4:0]  cam_reg,
    output logic [15:0] cam_wdata,
    input  logic [15:0] cam_rdata,
    input  logic        cam_ack,
    output logic        cam_timeout
);

    // Last count value spent in REQ before the access is abandoned
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_TIMEOUT - 1);

    logic [9:0]    addr_q;
    logic          ior_fall;
    logic          iow_fall;
    logic          hit;
    logic          both_low;
    logic [7:0]    lo_q;
    logic [15:0]   rd_q;
    logic [7:0]    wait_cnt;
    sm2201_state_t state;

    sm2201_isa_strobe_edge u_strobe_edge (
        .isa_clk   (isa_clk),
        .isa_reset (isa_reset),
        .isa_ale   (isa_ale),
        .isa_ior   (isa_ior),
        .isa_iow   (isa_iow),
        .isa_addr  (isa_addr),
        .addr_q    (addr_q),
        .ior_fall  (ior_fall),
        .iow_fall  (iow_fall)
    );

    // DMA cycles (AEN high) never belong to us, whatever the address says
    assign hit      = !isa_aen && (addr_q[9:SM2201_WIN_BITS] == BASE_ADDR[9:SM2201_WIN_BITS]);
    // Both strobes low at once is an illegal bus state and is ignored outright
    assign both_low = !isa_ior && !isa_iow;

    // Access FSM: even writes park the low byte, odd writes and even reads go to CAMAC
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            state       <= ST_IDLE;
            lo_q        <= '0;
            rd_q        <= RD_IDLE;
            wait_cnt    <= '0;
            isa_chrdy   <= 1'b1;
            cam_req     <= 1'b0;
            cam_write   <= 1'b0;
            cam_reg     <= '0;
            cam_wdata   <= '0;
            cam_timeout <= 1'b0;
        end else begin
            cam_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (hit && !both_low) begin
                        if (iow_fall) begin
                            if (!addr_q[0]) begin
                                lo_q <= isa_data_in;
                            end else begin
                                // lo_q may be stale if no even write preceded; that word is sent as-is
                                cam_wdata <= {isa_data_in, lo_q};
                                cam_write <= 1'b1;
                                cam_reg   <= addr_q[5:1];
                                cam_req   <= 1'b1;
                                isa_chrdy <= 1'b0;
                                wait_cnt  <= '0;
                                state     <= ST_REQ;
                            end
                        end else if (ior_fall && !addr_q[0]) begin
                            // Odd reads are served from the high byte cached by the last even read
                            cam_write <= 1'b0;
                            cam_reg   <= addr_q[5:1];
                            cam_req   <= 1'b1;
                            isa_chrdy <= 1'b0;
                            wait_cnt  <= '0;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    // An ack on the timeout edge still completes the access normally
                    if (cam_ack) begin
                        if (!cam_write) begin
                            rd_q <= cam_rdata;
                        end
                        cam_req   <= 1'b0;
                        isa_chrdy <= 1'b1;
                        state     <= ST_DONE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        if (!cam_write) begin
                            rd_q <= RD_IDLE;
                        end
                        cam_req     <= 1'b0;
                        isa_chrdy   <= 1'b1;
                        cam_timeout <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    // Hold off until the host has released its strobe so one cycle gives one request
                    if (isa_ior && isa_iow) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // ISA read-data path: byte select from the read cache plus the bus drive enable
    always_ff @(posedge isa_clk or negedge isa_reset) begin
        if (!isa_reset) begin
            isa_data_out <= '0;
            isa_data_oe  <= 1'b0;
        end else begin
            isa_data_oe  <= hit && !isa_ior && isa_iow;
            isa_data_out <= addr_q[0] ? rd_q[15:8] : rd_q[7:0];
        end
    end

endmodule

// File: tb/tb_sm2201_isa_cycle_decoder.sv
// Bench for the SM2201 ISA cycle decoder: directed vector table, corner sequences and random accesses.
// Latency: each access runs a fixed observation window longer than the wait timeout.
// Backpressure: the bench plays the CAMAC sequencer and acks after a chosen delay (or never).
module tb_sm2201_isa_cycle_decoder;

    localparam int TMO = 16;
    localparam int NA  = 99;   // ack delay meaning "never ack"

    logic        isa_clk = 1'b0;
    logic        isa_reset = 1'b0;
    logic        isa_ale = 1'b0;
    logic        isa_aen = 1'b0;
    logic        isa_ior = 1'b1;
    logic        isa_iow = 1'b1;
    logic [9:0]  isa_addr = '0;
    logic [7:0]  isa_data_in = '0;
    logic [7:0]  isa_data_out;
    logic        isa_data_oe;
    logic        isa_chrdy;
    logic        cam_req;
    logic        cam_write;
    logic [4:0]  cam_reg;
    logic [15:0] cam_wdata;
    logic [15:0] cam_rdata = '0;
    logic        cam_ack = 1'b0;
    logic        cam_timeout;

    int errors = 0;
    int checks = 0;

    // Reference state: last even-write byte and the 16-bit read cache
    logic [7:0]  m_lo = 8'h00;
    logic [15:0] m_rd = 16'hFFFF;

    typedef struct {
        logic [9:0]  addr;
        bit          wr;
        bit          aen;
        logic [7:0]  din;
        int          ack_dly;
        logic [15:0] rdata;
        int          exp_req;
        bit          exp_wr;
        logic [4:0]  exp_reg;
        logic [15:0] exp_wdata;
        int          exp_low;
        int          exp_to;
        bit          exp_oe;
        bit          chk_dout;
        logic [7:0]  exp_dout;
    } vec_t;

    typedef struct {
        int          req_edges;
        logic        wr;
        logic [4:0]  rg;
        logic [15:0] wdata;
        int          low;
        int          to;
        logic        oe;
        logic [7:0]  dout;
    } obs_t;

    sm2201_isa_cycle_decoder #(
        .BASE_ADDR    (10'h100),
        .WAIT_TIMEOUT (TMO)
    ) dut (
        .isa_clk      (isa_clk),
        .isa_reset    (isa_reset),
        .isa_ale      (isa_ale),
        .isa_aen      (isa_aen),
        .isa_ior      (isa_ior),
        .isa_iow      (isa_iow),
        .isa_addr     (isa_addr),
        .isa_data_in  (isa_data_in),
        .isa_data_out (isa_data_out),
        .isa_data_oe  (isa_data_oe),
        .isa_chrdy    (isa_chrdy),
        .cam_req      (cam_req),
        .cam_write    (cam_write),
        .cam_reg      (cam_reg),
        .cam_wdata    (cam_wdata),
        .cam_rdata    (cam_rdata),
        .cam_ack      (cam_ack),
        .cam_timeout  (cam_timeout)
    );

    always #5 isa_clk = ~isa_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [9:0] addr, input bit wr, input bit aen, input logic [7:0] din,
                                input int ack_dly, input logic [15:0] rdata, input int exp_req, input bit exp_wr,
                                input logic [4:0] exp_reg, input logic [15:0] exp_wdata, input int exp_low,
                                input int exp_to, input bit exp_oe, input bit chk_dout, input logic [7:0] exp_dout);
        vec_t v;
        v.addr = addr; v.wr = wr; v.aen = aen; v.din = din; v.ack_dly = ack_dly; v.rdata = rdata;
        v.exp_req = exp_req; v.exp_wr = exp_wr; v.exp_reg = exp_reg; v.exp_wdata = exp_wdata;
        v.exp_low = exp_low; v.exp_to = exp_to; v.exp_oe = exp_oe; v.chk_dout = chk_dout; v.exp_dout = exp_dout;
        return v;
    endfunction

    // Behavioural model of one complete ISA access; fills in expectations and updates m_lo/m_rd
    task automatic model_step(inout vec_t v);
        int  off;
        bit  hit;
        bit  odd;
        bit  late;
        bit  goes_out;
        off      = int'(v.addr) - 256;
        hit      = !v.aen && off >= 0 && off < 64;
        odd      = (v.addr % 2) == 1;
        late     = v.ack_dly >= TMO;      // ack would land after the wait budget is spent
        goes_out = hit && (v.wr ? odd : !odd);
        v.exp_req   = goes_out ? 1 : 0;
        v.exp_wr    = v.wr;
        v.exp_reg   = 5'(off / 2);
        v.exp_wdata = 16'(int'(v.din) * 256 + int'(m_lo));
        v.exp_low   = goes_out ? (late ? TMO : v.ack_dly + 1) : 0;
        v.exp_to    = (goes_out && late) ? 1 : 0;
        v.exp_oe    = hit && !v.wr;
        v.chk_dout  = hit && !v.wr;
        if (hit && v.wr && !odd) m_lo = v.din;
        if (goes_out && !v.wr) m_rd = late ? 16'hFFFF : v.rdata;
        v.exp_dout  = odd ? m_rd[15:8] : m_rd[7:0];
    endtask

    // Drive one ALE + strobe cycle, act as the CAMAC side, and record what the DUT did
    task automatic run_access(input vec_t v, output obs_t o);
        int cnt;
        bit prev;
        o.req_edges = 0; o.wr = 1'b0; o.rg = '0; o.wdata = '0; o.low = 0; o.to = 0;
        @(negedge isa_clk);
        isa_addr = v.addr;
        isa_aen  = v.aen;
        isa_ale  = 1'b1;
        @(negedge isa_clk);
        isa_ale     = 1'b0;
        isa_data_in = v.din;
        if (v.wr) isa_iow = 1'b0;
        else      isa_ior = 1'b0;
        cnt  = -1;
        prev = 1'b0;
        for (int i = 0; i < TMO + 8; i++) begin
            @(negedge isa_clk);
            cam_ack = 1'b0;
            if (cam_req && !prev) o.req_edges++;
            prev = cam_req;
            if (cam_req && cnt < 0) begin
                cnt     = 0;
                o.wr    = cam_write;
                o.rg    = cam_reg;
                o.wdata = cam_wdata;
            end else if (cnt >= 0) begin
                cnt++;
            end
            if (!isa_chrdy) o.low++;
            if (cam_timeout) o.to++;
            if (cnt == v.ack_dly) begin
                cam_ack   = 1'b1;
                cam_rdata = v.rdata;
            end
        end
        o.oe   = isa_data_oe;
        o.dout = isa_data_out;
        cam_ack = 1'b0;
        isa_ior = 1'b1;
        isa_iow = 1'b1;
        @(negedge isa_clk);
        @(negedge isa_clk);
        isa_aen = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t e, input obs_t o);
        check({tag, ".req_count"}, o.req_edges, e.exp_req);
        check({tag, ".chrdy_low"}, o.low, e.exp_low);
        check({tag, ".timeout"}, o.to, e.exp_to);
        check({tag, ".oe"}, o.oe, e.exp_oe);
        if (e.exp_req != 0) begin
            check({tag, ".cam_write"}, o.wr, e.exp_wr);
            check({tag, ".cam_reg"}, o.rg, e.exp_reg);
            if (e.wr) check({tag, ".cam_wdata"}, o.wdata, e.exp_wdata);
        end
        if (e.chk_dout) check({tag, ".data_out"}, o.dout, e.exp_dout);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t post[$];
        vec_t v;
        vec_t m;
        obs_t o;
        int   reqs;
        bit   seen;

        //           addr     wr aen din    ack  rdata      req wr reg wdata      low to oe chk dout
        tbl.push_back(mk(10'h100, 1, 0, 8'h34, NA, 16'h0000, 0, 1, 0,  16'h0000, 0,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h101, 1, 0, 8'h12, 5,  16'h0000, 1, 1, 0,  16'h1234, 6,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h102, 0, 0, 8'h00, 3,  16'hBEEF, 1, 0, 1,  16'h0000, 4,  0, 1, 1, 8'hEF));
        tbl.push_back(mk(10'h103, 0, 0, 8'h00, NA, 16'h0000, 0, 0, 0,  16'h0000, 0,  0, 1, 1, 8'hBE));
        tbl.push_back(mk(10'h0F0, 0, 0, 8'h00, 2,  16'h1111, 0, 0, 0,  16'h0000, 0,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h140, 1, 0, 8'h77, 2,  16'h0000, 0, 1, 0,  16'h0000, 0,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h140, 0, 0, 8'h00, 2,  16'h4444, 0, 0, 0,  16'h0000, 0,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h104, 0, 1, 8'h00, 2,  16'h2222, 0, 0, 0,  16'h0000, 0,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h104, 0, 0, 8'h00, NA, 16'h3333, 1, 0, 2,  16'h0000, 16, 1, 1, 1, 8'hFF));
        tbl.push_back(mk(10'h105, 0, 0, 8'h00, NA, 16'h0000, 0, 0, 0,  16'h0000, 0,  0, 1, 1, 8'hFF));
        tbl.push_back(mk(10'h13E, 1, 0, 8'hAA, NA, 16'h0000, 0, 1, 0,  16'h0000, 0,  0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h13F, 1, 0, 8'h55, 15, 16'h0000, 1, 1, 31, 16'h55AA, 16, 0, 0, 0, 8'h00));
        tbl.push_back(mk(10'h13E, 0, 0, 8'h00, 0,  16'h1357, 1, 0, 31, 16'h0000, 1,  0, 1, 1, 8'h57));
        tbl.push_back(mk(10'h13F, 0, 0, 8'h00, NA, 16'h0000, 0, 0, 0,  16'h0000, 0,  0, 1, 1, 8'h13));

        post.push_back(mk(10'h100, 1, 0, 8'h78, NA, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 0, 0, 8'h00));
        post.push_back(mk(10'h101, 1, 0, 8'h56, 2,  16'h0000, 1, 1, 0, 16'h5678, 3, 0, 0, 0, 8'h00));
        post.push_back(mk(10'h103, 0, 0, 8'h00, NA, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 1, 1, 8'hFF));

        // Reset values while reset is held
        #12;
        check("rst.data_out", isa_data_out, 8'h00);
        check("rst.data_oe", isa_data_oe, 1'b0);
        check("rst.chrdy", isa_chrdy, 1'b1);
        check("rst.cam_req", cam_req, 1'b0);
        check("rst.cam_write", cam_write, 1'b0);
        check("rst.cam_reg", cam_reg, 5'd0);
        check("rst.cam_wdata", cam_wdata, 16'h0000);
        check("rst.cam_timeout", cam_timeout, 1'b0);
        @(negedge isa_clk);
        isa_reset = 1'b1;

        // Directed vector table
        foreach (tbl[i]) begin
            run_access(tbl[i], o);
            compare($sformatf("tbl%0d", i), tbl[i], o);
            m = tbl[i];
            model_step(m);
        end

        // Both strobes low together at an odd address: nothing may happen
        @(negedge isa_clk);
        isa_addr = 10'h101;
        isa_ale  = 1'b1;
        @(negedge isa_clk);
        isa_ale = 1'b0;
        isa_ior = 1'b0;
        isa_iow = 1'b0;
        reqs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge isa_clk);
            if (cam_req) reqs++;
        end
        check("both_low.req", reqs, 0);
        check("both_low.oe", isa_data_oe, 1'b0);
        check("both_low.chrdy", isa_chrdy, 1'b1);
        isa_ior = 1'b1;
        isa_iow = 1'b1;
        repeat (2) @(negedge isa_clk);
        v = mk(10'h100, 0, 0, 8'h00, 1, 16'hA5C3, 1, 0, 0, 16'h0000, 2, 0, 1, 1, 8'hC3);
        run_access(v, o);
        compare("after_both_low", v, o);
        model_step(v);

        // Random accesses against the behavioural model
        for (int n = 0; n < 120; n++) begin
            v.addr    = ($urandom_range(0, 9) < 7) ? 10'(10'h100 + $urandom_range(0, 63)) : 10'($urandom);
            v.wr      = $urandom_range(0, 1) == 1;
            v.aen     = $urandom_range(0, 9) == 0;
            v.din     = 8'($urandom);
            v.ack_dly = $urandom_range(0, TMO + 1);
            v.rdata   = 16'($urandom);
            model_step(v);
            run_access(v, o);
            compare($sformatf("rnd%0d", n), v, o);
        end

        // Asynchronous reset in the middle of a pending read
        @(negedge isa_clk);
        isa_addr = 10'h106;
        isa_ale  = 1'b1;
        @(negedge isa_clk);
        isa_ale = 1'b0;
        isa_ior = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge isa_clk);
            seen = cam_req;
        end
        check("midreq.req_seen", seen, 1'b1);
        @(negedge isa_clk);
        #2;
        isa_reset = 1'b0;
        #1;
        check("midreq.cam_req", cam_req, 1'b0);
        check("midreq.chrdy", isa_chrdy, 1'b1);
        isa_ior = 1'b1;
        repeat (2) @(negedge isa_clk);
        isa_reset = 1'b1;
        m_lo = 8'h00;
        m_rd = 16'hFFFF;
        foreach (post[i]) begin
            run_access(post[i], o);
            compare($sformatf("post%0d", i), post[i], o);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
